// File: rtl/collision_pkg.sv
// Shared types and default geometry for the multi-pipe collision scanner.
package collision_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic KIND_PIPE  = 1'b0;
    localparam logic KIND_FLOOR = 1'b1;

    localparam int unsigned BIRD_W   = 4;
    localparam int unsigned BIRD_H   = 4;
    localparam int unsigned SCREEN_H = 120;

endpackage

// File: rtl/collision_scan_if.sv
// Handshake and geometry bundle between the game-state FSM and collision_scan.
interface collision_scan_if #(
    parameter int unsigned N_PIPES = 4,
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7
);
    localparam int unsigned IDX_W = (N_PIPES > 1) ? $clog2(N_PIPES) : 1;

    logic                   start;
    logic                   clear;
    logic [X_W-1:0]         bird_x;
    logic [Y_W-1:0]         bird_y;
    logic [N_PIPES*X_W-1:0] pipe_x;
    logic [N_PIPES*Y_W-1:0] pipe_gap_y;
    logic [N_PIPES-1:0]     pipe_valid;
    logic [4:0]             pipe_w;
    logic [Y_W-1:0]         gap_h;
    logic                   busy;
    logic                   done;
    logic                   collision;
    logic [IDX_W-1:0]       hit_idx;
    logic                   hit_kind;

    modport master (
        output start, clear, bird_x, bird_y, pipe_x, pipe_gap_y, pipe_valid, pipe_w, gap_h,
        input  busy, done, collision, hit_idx, hit_kind
    );

    modport slave (
        input  start, clear, bird_x, bird_y, pipe_x, pipe_gap_y, pipe_valid, pipe_w, gap_h,
        output busy, done, collision, hit_idx, hit_kind
    );

endinterface

// File: rtl/collision_pipe_test.sv
// Combinational overlap test of the bird hitbox against one pipe channel.
// All sums are one bit wider than the operands so nothing wraps.
module collision_pipe_test #(
    parameter int unsigned X_W    = 8,
    parameter int unsigned Y_W    = 7,
    parameter int unsigned BIRD_W = collision_pkg::BIRD_W,
    parameter int unsigned BIRD_H = collision_pkg::BIRD_H
) (
    input  logic [X_W-1:0] birdX,
    input  logic [Y_W-1:0] birdY,
    input  logic [X_W-1:0] pipeX,
    input  logic [Y_W-1:0] gapY,
    input  logic           pipeValid,
    input  logic [4:0]     pipeW,
    input  logic [Y_W-1:0] gapH,
    output logic           hit
);

    logic [X_W:0] birdRight;
    logic [X_W:0] pipeRight;
    logic [Y_W:0] birdBottom;
    logic [Y_W:0] gapBottom;
    logic         xOverlap;
    logic         yOutside;

    // Overlap and gap tests on widened operands.
    always_comb begin
        birdRight  = {1'b0, birdX} + (X_W+1)'(BIRD_W);
        pipeRight  = {1'b0, pipeX} + (X_W+1)'(pipeW);
        birdBottom = {1'b0, birdY} + (Y_W+1)'(BIRD_H);
        gapBottom  = {1'b0, gapY} + {1'b0, gapH};
        xOverlap   = (birdRight > {1'b0, pipeX}) && ({1'b0, birdX} <= pipeRight);
        yOutside   = (birdY < gapY) || (birdBottom > gapBottom);
        hit        = pipeValid && xOverlap && yOutside;
    end

endmodule

// File: rtl/collision_scan.sv
// Sequential multi-pipe collision scanner: one channel per clock on a start/done
// handshake, with a sticky first-hit record.
// Optional floor check on the channel-0 cycle is enabled by defining COLLISION_FLOOR_EN.
module collision_scan #(
    parameter int unsigned N_PIPES  = 4,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned BIRD_W   = collision_pkg::BIRD_W,
    parameter int unsigned BIRD_H   = collision_pkg::BIRD_H,
    parameter int unsigned SCREEN_H = collision_pkg::SCREEN_H
) (
    input logic              clk,
    input logic              reset,
    collision_scan_if.slave  bus
);
    import collision_pkg::*;

    localparam int unsigned IDX_W = (N_PIPES > 1) ? $clog2(N_PIPES) : 1;

    state_t           stateQ, stateD;
    logic [IDX_W-1:0] cntQ, cntD;
    logic             loadSnap;

    logic [X_W-1:0]   birdXQ;
    logic [Y_W-1:0]   birdYQ;
    logic [4:0]       pipeWQ;
    logic [Y_W-1:0]   gapHQ;

    logic [X_W-1:0]   selX;
    logic [Y_W-1:0]   selGapY;
    logic             selValid;
    logic             pipeHit;
    logic             floorHit;
    logic             anyHit;

    logic             collisionQ;
    logic [IDX_W-1:0] hitIdxQ;

    // State and channel counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= IDLE;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        loadSnap = 1'b0;
        unique case (stateQ)
            IDLE: begin
                if (bus.start) begin
                    stateD   = SCAN;
                    cntD     = '0;
                    loadSnap = 1'b1;
                end
            end
            SCAN: begin
                if (cntQ == IDX_W'(N_PIPES - 1)) begin
                    stateD = DONE;
                    cntD   = '0;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            DONE: stateD = IDLE;
            default: begin
                stateD = IDLE;
                cntD   = '0;
            end
        endcase
    end

    // Bird position and shared pipe geometry are frozen for the whole scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            birdXQ <= '0;
            birdYQ <= '0;
            pipeWQ <= '0;
            gapHQ  <= '0;
        end else if (loadSnap) begin
            birdXQ <= bus.bird_x;
            birdYQ <= bus.bird_y;
            pipeWQ <= bus.pipe_w;
            gapHQ  <= bus.gap_h;
        end
    end

    // Channel mux: per-pipe inputs are read live for the channel under test.
    always_comb begin
        selX     = '0;
        selGapY  = '0;
        selValid = 1'b0;
        for (int i = 0; i < int'(N_PIPES); i++) begin
            if (cntQ == IDX_W'(i)) begin
                selX     = bus.pipe_x[i*X_W +: X_W];
                selGapY  = bus.pipe_gap_y[i*Y_W +: Y_W];
                selValid = bus.pipe_valid[i];
            end
        end
    end

    collision_pipe_test #(
        .X_W    (X_W),
        .Y_W    (Y_W),
        .BIRD_W (BIRD_W),
        .BIRD_H (BIRD_H)
    ) uPipeTest (
        .birdX     (birdXQ),
        .birdY     (birdYQ),
        .pipeX     (selX),
        .gapY      (selGapY),
        .pipeValid (selValid),
        .pipeW     (pipeWQ),
        .gapH      (gapHQ),
        .hit       (pipeHit)
    );

`ifdef COLLISION_FLOOR_EN
    logic [Y_W:0] birdBottom;
    logic         hitKindQ;

    // Floor is checked once per scan, on the channel-0 cycle.
    always_comb begin
        birdBottom = {1'b0, birdYQ} + (Y_W+1)'(BIRD_H);
        floorHit   = (stateQ == SCAN) && (cntQ == '0) && (birdBottom > (Y_W+1)'(SCREEN_H));
    end
`else
    logic unusedScreenH;

    // Without the floor check the screen height plays no part.
    always_comb begin
        floorHit      = 1'b0;
        unusedScreenH = ^SCREEN_H;
    end
`endif

    // A hit only counts while a channel is actually being evaluated.
    always_comb begin
        anyHit = (stateQ == SCAN) && (pipeHit || floorHit);
    end

    // Sticky first-hit record; clear wins over a same-cycle hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            collisionQ <= 1'b0;
            hitIdxQ    <= '0;
`ifdef COLLISION_FLOOR_EN
            hitKindQ   <= KIND_PIPE;
`endif
        end else if (bus.clear) begin
            collisionQ <= 1'b0;
            hitIdxQ    <= '0;
`ifdef COLLISION_FLOOR_EN
            hitKindQ   <= KIND_PIPE;
`endif
        end else if (anyHit && !collisionQ) begin
            collisionQ <= 1'b1;
            hitIdxQ    <= floorHit ? '0 : cntQ;
`ifdef COLLISION_FLOOR_EN
            hitKindQ   <= floorHit ? KIND_FLOOR : KIND_PIPE;
`endif
        end
    end

    // Output decode.
    always_comb begin
        bus.busy      = (stateQ == SCAN);
        bus.done      = (stateQ == DONE);
        bus.collision = collisionQ;
        bus.hit_idx   = hitIdxQ;
`ifdef COLLISION_FLOOR_EN
        bus.hit_kind  = hitKindQ;
`else
        bus.hit_kind  = KIND_PIPE;
`endif
    end

endmodule

// File: doc/collision_scan.md
Name: collision_scan

Overview:
- Multi-pipe collision detector. Generalises the single-pipe checker to N_PIPES pipe channels, parametrised coordinate widths and bird hitbox.
- Scans the channels sequentially, one per clock, on a start/done handshake.
- Latches a sticky collision flag and reports which pipe, or the floor, was hit.
- Sits between the game-state FSM, which pulses start once per frame after movement updates, and the game-over logic.

Parameters:
- N_PIPES, 4, number of pipe channels scanned.
- X_W, 8, x-coordinate width.
- Y_W, 7, y-coordinate width.
- BIRD_W, 4, bird hitbox width in pixels.
- BIRD_H, 4, bird hitbox height in pixels.
- SCREEN_H, 120, playfield height; floor limit.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a scan; accepted only in IDLE.
- clear  in  1  clears the sticky collision result.
- bird_x  in  X_W  bird left edge.
- bird_y  in  Y_W  bird top edge.
- pipe_x  in  N_PIPES*X_W  flattened pipe left edges; channel i at bits [i*X_W +: X_W].
- pipe_gap_y  in  N_PIPES*Y_W  flattened gap top edges.
- pipe_valid  in  N_PIPES  channel i is on screen.
- pipe_w  in  5  pipe width minus 1; pipe spans [pipe_x, pipe_x+pipe_w].
- gap_h  in  Y_W  gap height in pixels.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when the scan completes.
- collision  out  1  sticky collision flag.
- hit_idx  out  $clog2(N_PIPES)  channel of the first recorded hit.
- hit_kind  out  1  0 = pipe, 1 = floor.

Behaviour:
- Reset, synchronous active-high: state IDLE, channel counter 0, all outputs 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on start.
  - Snapshot bird_x, bird_y, pipe_w and gap_h into registers.
  - busy=1 from the next cycle.
- SCAN evaluates channel cnt each cycle, cnt counting 0..N_PIPES-1.
  - After channel N_PIPES-1, go to DONE.
- DONE asserts done=1 for exactly one cycle, busy=0, then returns to IDLE.
- Latency: start accepted at cycle 0; done high at cycle N_PIPES+1.
- pipe_x, pipe_gap_y and pipe_valid are read live. The caller holds them stable while busy.
- Hit test for channel i, with all sums in width+1 bits (no wrap, no underflow):
  - X overlap: bird_x + BIRD_W > pipe_x[i] AND bird_x <= pipe_x[i] + pipe_w.
  - Y outside gap: bird_y < gap_y[i] OR bird_y + BIRD_H > gap_y[i] + gap_h.
  - hit = pipe_valid[i] AND X overlap AND Y outside gap.
- Sticky result: the first hit while collision=0 sets collision=1 and records hit_idx and hit_kind.
  - Later hits never overwrite the recorded hit.
  - Scans started while collision=1 run normally, with done pulsing; all outputs stay unchanged.
- start while busy or in DONE: ignored, no queuing.
- clear:
  - Next cycle: collision=0, hit_idx=0, hit_kind=0.
  - A hit evaluated in the same cycle as clear is lost; clear has priority.
  - clear mid-scan does not abort the scan; later channels can set collision again.
  - clear and start together: both take effect.
- Reset mid-scan: immediate return to IDLE; no done pulse.
- pipe_valid all 0: the scan still takes N_PIPES cycles; collision is unchanged.

Optional Feature:
- Macro: COLLISION_FLOOR_EN.
- Defined:
  - During channel-0 cycle, floor_hit = bird_y + BIRD_H > SCREEN_H, computed at Y_W+1 bits.
  - Floor takes priority over a channel-0 pipe hit in the same cycle: hit_kind=1, hit_idx=0.
- Undefined:
  - No floor check; hit_kind is tied to 0.
  - The SCREEN_H parameter is unused.

Decomposition:
- Package collision_pkg holds:
  - state enum {IDLE, SCAN, DONE};
  - hit_kind constants KIND_PIPE=0, KIND_FLOOR=1;
  - default geometry constants BIRD_W, BIRD_H, SCREEN_H.
- One natural sub-module: collision_pipe_test.
  - Purely combinational overlap test for one channel.
  - Inputs: snapshot bird position, one pipe's x/gap_y/valid, pipe_w and gap_h. Output: hit.
  - Instantiated once and driven through a channel mux indexed by cnt.

Test Plan (defaults; pipe_w=10, gap_h=30; only channel 2 valid at pipe_x=60, gap_y=40 unless noted):
- Reset then idle: busy, done, collision, hit_idx and hit_kind all 0; start held during reset has no effect.
- Bird (62,50), start -> done pulse at cycle 5, collision=0.
- Bird (62,20), start -> collision=1, hit_idx=2, hit_kind=0 at cycle 5.
- Edge widths, each run in a fresh scan after clear:
  - Channel 0 pipe_x=2, bird (0,5) -> collision=1, hit_idx=0; no underflow miss.
  - Channel 0 pipe_x=250, bird (3,5) -> collision=0; no wrap false hit.
- Sticky behaviour:
  - After a hit, start with safe bird (62,50) -> collision stays 1, hit_idx=2.
  - start pulsed while busy -> ignored; exactly one done pulse.
  - clear -> collision=0 on the next cycle.
- Floor: bird (10,117), no pipes valid.
  - With COLLISION_FLOOR_EN: collision=1, hit_kind=1.
  - Without it: collision=0.
